// File: rtl/wb_arb.sv
// Writeback arbiter: accepts one finished result per cycle from scalu, mcalu or lsq
// and broadcasts it for one cycle. Define WB_ARB_RR_EN for round-robin priority.
module wb_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        rob_flush,

    input  logic        scalu_valid,
    input  logic        scalu_error,
    input  logic [4:0]  scalu_ecause,
    input  logic [6:0]  scalu_robid,
    input  logic [5:0]  scalu_rd,
    input  logic [31:0] scalu_result,

    input  logic        mcalu_valid,
    input  logic        mcalu_error,
    input  logic [4:0]  mcalu_ecause,
    input  logic [6:0]  mcalu_robid,
    input  logic [5:0]  mcalu_rd,
    input  logic [31:0] mcalu_result,

    input  logic        lsq_valid,
    input  logic        lsq_error,
    input  logic [4:0]  lsq_ecause,
    input  logic [6:0]  lsq_robid,
    input  logic [5:0]  lsq_rd,
    input  logic [31:0] lsq_result,

    output logic        wb_scalu_stall,
    output logic        wb_mcalu_stall,
    output logic        wb_lsq_stall,

    output logic        wb_valid,
    output logic        wb_error,
    output logic [4:0]  wb_ecause,
    output logic [6:0]  wb_robid,
    output logic [5:0]  wb_rd,
    output logic [31:0] wb_result
);

    // Handshake: producer X transfers in a cycle where X_valid=1 and wb_X_stall=0;
    // while stalled it holds valid and all fields stable. No downstream backpressure.
    logic [2:0] req;
    logic [2:0] grant;

    assign req = {lsq_valid, mcalu_valid, scalu_valid};

`ifdef WB_ARB_RR_EN
    logic [1:0] ptr;

    // Search starts at ptr and wraps scalu -> mcalu -> lsq; ptr=3 behaves as 0.
    always_comb begin
        grant = 3'b000;
        if (!rst && !rob_flush) begin
            case (ptr)
                2'd1: begin
                    if (req[1])      grant = 3'b010;
                    else if (req[2]) grant = 3'b100;
                    else if (req[0]) grant = 3'b001;
                end
                2'd2: begin
                    if (req[2])      grant = 3'b100;
                    else if (req[0]) grant = 3'b001;
                    else if (req[1]) grant = 3'b010;
                end
                default: begin
                    if (req[0])      grant = 3'b001;
                    else if (req[1]) grant = 3'b010;
                    else if (req[2]) grant = 3'b100;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rob_flush) begin
            ptr <= 2'd0;
        end else if (grant[0]) begin
            ptr <= 2'd1;
        end else if (grant[1]) begin
            ptr <= 2'd2;
        end else if (grant[2]) begin
            ptr <= 2'd0;
        end
    end
`else
    // Fixed priority: lsq > mcalu > scalu.
    always_comb begin
        grant = 3'b000;
        if (!rst && !rob_flush) begin
            if (req[2])      grant = 3'b100;
            else if (req[1]) grant = 3'b010;
            else if (req[0]) grant = 3'b001;
        end
    end
`endif

    assign wb_scalu_stall = scalu_valid & ~grant[0];
    assign wb_mcalu_stall = mcalu_valid & ~grant[1];
    assign wb_lsq_stall   = lsq_valid   & ~grant[2];

    logic        sel_error;
    logic [4:0]  sel_ecause;
    logic [6:0]  sel_robid;
    logic [5:0]  sel_rd;
    logic [31:0] sel_result;

    always_comb begin
        sel_error  = scalu_error;
        sel_ecause = scalu_ecause;
        sel_robid  = scalu_robid;
        sel_rd     = scalu_rd;
        sel_result = scalu_result;
        if (grant[2]) begin
            sel_error  = lsq_error;
            sel_ecause = lsq_ecause;
            sel_robid  = lsq_robid;
            sel_rd     = lsq_rd;
            sel_result = lsq_result;
        end else if (grant[1]) begin
            sel_error  = mcalu_error;
            sel_ecause = mcalu_ecause;
            sel_robid  = mcalu_robid;
            sel_rd     = mcalu_rd;
            sel_result = mcalu_result;
        end
    end

    // Grant is already empty during rob_flush, so wb_valid drops without a separate branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid  <= 1'b0;
            wb_error  <= 1'b0;
            wb_ecause <= 5'd0;
            wb_robid  <= 7'd0;
            wb_rd     <= 6'd0;
            wb_result <= 32'd0;
        end else begin
            wb_valid <= |grant;
            if (|grant) begin
                wb_error  <= sel_error;
                wb_ecause <= sel_ecause;
                wb_robid  <= sel_robid;
                wb_rd     <= sel_rd;
                wb_result <= sel_result;
            end
        end
    end

endmodule

// File: tb/tb_wb_arb.sv
// Randomized bench for wb_arb: a priority model predicts grants; a monitor checks broadcasts.
// Honors WB_ARB_RR_EN the same way as the design.
module tb_wb_arb;

  typedef struct packed {
    logic        error;
    logic [4:0]  ecause;
    logic [6:0]  robid;
    logic [5:0]  rd;
    logic [31:0] result;
  } res_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rob_flush;
  logic [2:0] vld;
  res_t       p0, p1, p2;

  logic        wb_scalu_stall, wb_mcalu_stall, wb_lsq_stall;
  logic        wb_valid, wb_error;
  logic [4:0]  wb_ecause;
  logic [6:0]  wb_robid;
  logic [5:0]  wb_rd;
  logic [31:0] wb_result;

  wb_arb dut (
    .clk            (clk),
    .rst            (rst),
    .rob_flush      (rob_flush),
    .scalu_valid    (vld[0]),
    .scalu_error    (p0.error),
    .scalu_ecause   (p0.ecause),
    .scalu_robid    (p0.robid),
    .scalu_rd       (p0.rd),
    .scalu_result   (p0.result),
    .mcalu_valid    (vld[1]),
    .mcalu_error    (p1.error),
    .mcalu_ecause   (p1.ecause),
    .mcalu_robid    (p1.robid),
    .mcalu_rd       (p1.rd),
    .mcalu_result   (p1.result),
    .lsq_valid      (vld[2]),
    .lsq_error      (p2.error),
    .lsq_ecause     (p2.ecause),
    .lsq_robid      (p2.robid),
    .lsq_rd         (p2.rd),
    .lsq_result     (p2.result),
    .wb_scalu_stall (wb_scalu_stall),
    .wb_mcalu_stall (wb_mcalu_stall),
    .wb_lsq_stall   (wb_lsq_stall),
    .wb_valid       (wb_valid),
    .wb_error       (wb_error),
    .wb_ecause      (wb_ecause),
    .wb_robid       (wb_robid),
    .wb_rd          (wb_rd),
    .wb_result      (wb_result)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int ptr_m = 0;
  logic [50:0] exp_q[$];
  int exp_cyc_q[$];
  logic [2:0] pend;
  int g;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic res_t get_src(input int k);
    case (k)
      0: get_src = p0;
      1: get_src = p1;
      default: get_src = p2;
    endcase
  endfunction

  function automatic res_t rand_res();
    res_t r;
    r.error  = 1'($urandom_range(1, 0));
    r.ecause = 5'($urandom_range(31, 0));
    r.robid  = 7'($urandom_range(127, 0));
    r.rd     = 6'($urandom_range(63, 0));
    r.result = $urandom;
    return r;
  endfunction

  task automatic set_src(input int k, input res_t r);
    case (k)
      0: p0 = r;
      1: p1 = r;
      default: p2 = r;
    endcase
  endtask

  // Reference priority: first pending producer in the priority order, or -1.
  function automatic int model_grant(input logic [2:0] v);
    int found;
    found = -1;
`ifdef WB_ARB_RR_EN
    for (int i = 2; i >= 0; i--) begin
      if (v[(ptr_m + i) % 3]) found = (ptr_m + i) % 3;
    end
`else
    for (int k = 0; k <= 2; k++) begin
      if (v[k]) found = k;
    end
`endif
    return found;
  endfunction

  // driver: called 2 time units after a rising edge; returns 2 units after the next one
  task automatic step(input logic [2:0] v, input logic fl, output int gr);
    vld = v;
    rob_flush = fl;
    #1;
    gr = (rst || fl) ? -1 : model_grant(v);
    check("stall_scalu", 64'(wb_scalu_stall), 64'(v[0] && gr != 0));
    check("stall_mcalu", 64'(wb_mcalu_stall), 64'(v[1] && gr != 1));
    check("stall_lsq",   64'(wb_lsq_stall),   64'(v[2] && gr != 2));
    if (gr >= 0) begin
      exp_q.push_back(get_src(gr));
      exp_cyc_q.push_back(cyc + 1);
      ptr_m = (gr + 1) % 3;
    end
    if (rst || fl) ptr_m = 0;
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    for (int n = 0; n < 6 && pend != 3'b000; n++) begin
      step(pend, 1'b0, g);
      if (g >= 0) pend[g] = 1'b0;
    end
    check("drain_done", 64'(pend), 64'(0));
  endtask

  // monitor / scoreboard
  initial begin
    logic due;
    logic [50:0] e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      due = (exp_q.size() > 0) && (exp_cyc_q[0] == cyc);
      check("wb_valid", 64'(wb_valid), 64'(due));
      if (due) begin
        e = exp_q.pop_front();
        void'(exp_cyc_q.pop_front());
        check("wb_fields", 64'({wb_error, wb_ecause, wb_robid, wb_rd, wb_result}), 64'(e));
      end
    end
  end

  initial begin
    rst = 1'b1;
    rob_flush = 1'b0;
    vld = 3'b000;
    p0 = '0;
    p1 = '0;
    p2 = '0;
    pend = 3'b000;
    repeat (2) @(posedge clk);
    #2;
    step(3'b111, 1'b0, g);
    step(3'b000, 1'b0, g);
    check("reset_regs", 64'({wb_valid, wb_error, wb_ecause, wb_robid, wb_rd, wb_result}), 64'(0));
    rst = 1'b0;
    repeat (3) step(3'b000, 1'b0, g);

    // single issue from mcalu
    p1 = {1'b0, 5'd0, 7'h12, 6'h05, 32'hDEADBEEF};
    step(3'b010, 1'b0, g);
    repeat (2) step(3'b000, 1'b0, g);

    // three-way contention starting from ptr=0
    step(3'b000, 1'b1, g);
    for (int k = 0; k < 3; k++) set_src(k, rand_res());
    pend = 3'b111;
    drain();
    step(3'b000, 1'b0, g);

    // error passthrough
    p2 = rand_res();
    p2.error = 1'b1;
    p2.ecause = 5'd5;
    step(3'b100, 1'b0, g);
    step(3'b000, 1'b0, g);

    // flush mid-contention
    p0 = rand_res();
    p2 = rand_res();
    pend = 3'b101;
    step(pend, 1'b1, g);
    drain();

    // randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      logic fl;
      for (int k = 0; k < 3; k++) begin
        if (!pend[k] && $urandom_range(1, 0) == 1) begin
          set_src(k, rand_res());
          pend[k] = 1'b1;
        end
      end
      fl = ($urandom_range(19, 0) == 0);
      step(pend, fl, g);
      if (g >= 0) pend[g] = 1'b0;
    end
    pend = 3'b000;
    repeat (3) step(3'b000, 1'b0, g);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
